// File: rtl/ex_stage_if.sv
//------------------------------------------------------------------------------
// Module   : ex_stage_if
// Brief    : Decode->EX->MEM signal bundle for the execute stage.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ex_stage_if #(
    parameter int DATA_W = 16
);
    logic              state;
    logic [DATA_W-1:0] ex_ir;
    logic [DATA_W-1:0] reg_A;
    logic [DATA_W-1:0] reg_B;
    logic [DATA_W-1:0] smdr;
    logic [DATA_W-1:0] ALUo;
    logic              jump;
    logic [DATA_W-1:0] mem_ir;
    logic [DATA_W-1:0] reg_C;
    logic [DATA_W-1:0] smdr1;
    logic              dw;
    logic              zf;
    logic              nf;
    logic              cf;

    // Driver side: decode/control feeding EX and observing its results.
    modport master (
        output state, ex_ir, reg_A, reg_B, smdr,
        input  ALUo, jump, mem_ir, reg_C, smdr1, dw, zf, nf, cf
    );

    // The execute stage itself.
    modport slave (
        input  state, ex_ir, reg_A, reg_B, smdr,
        output ALUo, jump, mem_ir, reg_C, smdr1, dw, zf, nf, cf
    );
endinterface

`default_nettype wire

// File: rtl/ex_stage.sv
//------------------------------------------------------------------------------
// Module   : ex_stage
// Brief    : 16-bit pipeline execute stage: ALU, flags, branch resolve, MEM latches.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ex_stage #(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = 4
) (
    input  wire logic   clock,
    input  wire logic   reset,
    ex_stage_if.slave   bus
);
    localparam logic       EXEC   = 1'b1;

    localparam logic [4:0] NOP    = 5'b00000;
    localparam logic [4:0] LOAD   = 5'b00010;
    localparam logic [4:0] STORE  = 5'b00011;
    localparam logic [4:0] SHL    = 5'b00100;
    localparam logic [4:0] CAL    = 5'b00101;
    localparam logic [4:0] SHR    = 5'b00110;
    localparam logic [4:0] CAR    = 5'b00111;
    localparam logic [4:0] ADD    = 5'b01000;
    localparam logic [4:0] ADDI   = 5'b01001;
    localparam logic [4:0] SUB    = 5'b01010;
    localparam logic [4:0] SUBI   = 5'b01011;
    localparam logic [4:0] CMP    = 5'b01100;
    localparam logic [4:0] AND_OP = 5'b01101;
    localparam logic [4:0] OR_OP  = 5'b01110;
    localparam logic [4:0] XOR_OP = 5'b01111;
    localparam logic [4:0] MOVI   = 5'b10000;
    localparam logic [4:0] ADDC   = 5'b10001;
    localparam logic [4:0] SUBC   = 5'b10010;
    localparam logic [4:0] JZ     = 5'b11010;
    localparam logic [4:0] JNZ    = 5'b11011;
    localparam logic [4:0] JS     = 5'b11100;
    localparam logic [4:0] JNS    = 5'b11101;
    localparam logic [4:0] JC     = 5'b11110;
    localparam logic [4:0] JNC    = 5'b11111;

    logic [4:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W:0]    sum;
    logic [DATA_W-1:0]  alu;
    logic               cf_next;
    logic               upd_zn;
    logic               upd_c;
    logic               jump;

    logic [DATA_W-1:0]  mem_ir_q, mem_ir_d;
    logic [DATA_W-1:0]  reg_c_q,  reg_c_d;
    logic [DATA_W-1:0]  smdr1_q,  smdr1_d;
    logic               dw_q,     dw_d;
    logic               zf_q,     zf_d;
    logic               nf_q,     nf_d;
    logic               cf_q,     cf_d;

    assign op    = bus.ex_ir[DATA_W-1:DATA_W-5];
    assign shamt = bus.reg_B[SHAMT_W-1:0];

    always_comb begin
        sum     = '0;
        alu     = '0;
        cf_next = cf_q;
        upd_zn  = 1'b0;
        upd_c   = 1'b0;
        case (op)
            LOAD, STORE, JZ, JNZ, JS, JNS, JC, JNC: begin
                alu = bus.reg_A + bus.reg_B;
            end
            ADD, ADDI, ADDC: begin
                sum     = {1'b0, bus.reg_A} + {1'b0, bus.reg_B}
                        + {{DATA_W{1'b0}}, (op == ADDC) & cf_q};
                alu     = sum[DATA_W-1:0];
                cf_next = sum[DATA_W];
                upd_zn  = 1'b1;
                upd_c   = 1'b1;
            end
            SUB, SUBI, CMP, SUBC: begin
                // Bit 16 of the 17-bit difference is set exactly when A < B + cin.
                sum     = {1'b0, bus.reg_A} - {1'b0, bus.reg_B}
                        - {{DATA_W{1'b0}}, (op == SUBC) & cf_q};
                alu     = sum[DATA_W-1:0];
                cf_next = sum[DATA_W];
                upd_zn  = 1'b1;
                upd_c   = 1'b1;
            end
            AND_OP: begin alu = bus.reg_A & bus.reg_B; upd_zn = 1'b1; end
            OR_OP:  begin alu = bus.reg_A | bus.reg_B; upd_zn = 1'b1; end
            XOR_OP: begin alu = bus.reg_A ^ bus.reg_B; upd_zn = 1'b1; end
            SHL:    begin alu = bus.reg_A << shamt;    upd_zn = 1'b1; end
            SHR:    begin alu = bus.reg_A >> shamt;    upd_zn = 1'b1; end
            // Rotates shift a doubled copy of A and keep the wrapped half.
            CAL: begin
                alu    = DATA_W'(({bus.reg_A, bus.reg_A} << shamt) >> DATA_W);
                upd_zn = 1'b1;
            end
            CAR: begin
                alu    = DATA_W'({bus.reg_A, bus.reg_A} >> shamt);
                upd_zn = 1'b1;
            end
            MOVI:    alu = bus.reg_B;
            default: alu = '0;
        endcase
    end

    always_comb begin
        jump = 1'b0;
        if (bus.state == EXEC) begin
            case (op)
                JZ:      jump = zf_q;
                JNZ:     jump = ~zf_q;
                JS:      jump = nf_q;
                JNS:     jump = ~nf_q;
                JC:      jump = cf_q;
                JNC:     jump = ~cf_q;
                default: jump = 1'b0;
            endcase
        end
    end

    always_comb begin
        mem_ir_d = mem_ir_q;
        reg_c_d  = reg_c_q;
        smdr1_d  = smdr1_q;
        dw_d     = dw_q;
        zf_d     = zf_q;
        nf_d     = nf_q;
        cf_d     = cf_q;
        if (bus.state == EXEC) begin
            mem_ir_d = bus.ex_ir;
            reg_c_d  = alu;
            smdr1_d  = bus.smdr;
            dw_d     = (op == STORE);
            if (upd_zn) begin
                zf_d = (alu == '0);
                nf_d = alu[DATA_W-1];
            end
            if (upd_c) begin
                cf_d = cf_next;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_ir_q <= '0;
            reg_c_q  <= '0;
            smdr1_q  <= '0;
            dw_q     <= 1'b0;
            zf_q     <= 1'b0;
            nf_q     <= 1'b0;
            cf_q     <= 1'b0;
        end else begin
            mem_ir_q <= mem_ir_d;
            reg_c_q  <= reg_c_d;
            smdr1_q  <= smdr1_d;
            dw_q     <= dw_d;
            zf_q     <= zf_d;
            nf_q     <= nf_d;
            cf_q     <= cf_d;
        end
    end

    assign bus.ALUo   = alu;
    assign bus.jump   = jump;
    assign bus.mem_ir = mem_ir_q;
    assign bus.reg_C  = reg_c_q;
    assign bus.smdr1  = smdr1_q;
    assign bus.dw     = dw_q;
    assign bus.zf     = zf_q;
    assign bus.nf     = nf_q;
    assign bus.cf     = cf_q;

endmodule

`default_nettype wire
